// File: rtl/lift53_stream_if.sv
// Stream bundle for the 5/3 lifting stage: sample input channel and
// coefficient-pair output channel, each with a valid/ready handshake.
// The slave modport is the lifting stage's view of the bundle; the master
// modport is the surrounding pipeline's view (line reader + packer).
interface lift53_stream_if #(
    parameter int DW = 8
);
    logic                 s_valid;
    logic [DW-1:0]        s_data;
    logic                 s_ready;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW+1:0] m_L;
    logic signed [DW+1:0] m_H;
    logic                 m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_L, m_H, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_L, m_H, m_last
    );
endinterface

// File: rtl/lift53_stream.sv
// Streaming 1-D LeGall 5/3 forward integer lifting stage.
// Takes LINE_LEN unsigned samples per line and produces LINE_LEN/2 (L, H)
// coefficient pairs, mirroring the line at both ends. Each pair is formed
// on the accept that delivers the right-hand neighbour x[2n+2] (or, for the
// last pair, the final odd sample, whose right neighbour mirrors to x[N-2]).
// A single output register holds the pair; input is stalled while it is full
// and not being drained.
// The interface instance must be built with the same DW as this module.
module lift53_stream #(
    parameter int DW       = 8,
    parameter int LINE_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    lift53_stream_if.slave   bus
);

    localparam int IW = $clog2(LINE_LEN);
    localparam int W  = DW + 3;
    localparam logic [IW-1:0]       LAST_IDX  = IW'(LINE_LEN - 1);
    localparam logic [IW-1:0]       FIRST_EMIT = IW'(2);
    localparam logic signed [W-1:0] ROUND     = W'(2);

    generate
        if ((LINE_LEN % 2) != 0 || LINE_LEN < 4) begin : g_bad_line_len
            $error("lift53_stream: LINE_LEN must be even and at least 4");
        end
    endgenerate

    logic [IW-1:0]       idx;
    logic [DW-1:0]       x_even;
    logic [DW-1:0]       x_odd;
    logic signed [W-1:0] h_prev;

    logic                accept;
    logic                is_even;
    logic                is_last;
    logic                emit;
    logic signed [W-1:0] s_ext;
    logic signed [W-1:0] e_ext;
    logic signed [W-1:0] o_ext;
    logic signed [W-1:0] odd_val;
    logic signed [W-1:0] right_val;
    logic signed [W-1:0] h_new;
    logic signed [W-1:0] h_left;
    logic signed [W-1:0] l_new;
    logic                unused_l_top;

    assign bus.s_ready = !bus.m_valid || bus.m_ready;

    // Predict/update datapath for the pair completed by the current sample.
    // On the last sample the incoming value is the odd sample and the right
    // neighbour mirrors back to the stored even sample; pair 0 has no left
    // H, so it reuses its own H.
    always_comb begin
        accept    = bus.s_valid && bus.s_ready;
        is_even   = ~idx[0];
        is_last   = (idx == LAST_IDX);
        emit      = accept && ((is_even && (idx != '0)) || is_last);
        s_ext     = signed'(W'(bus.s_data));
        e_ext     = signed'(W'(x_even));
        o_ext     = signed'(W'(x_odd));
        odd_val   = is_last ? s_ext : o_ext;
        right_val = is_last ? e_ext : s_ext;
        h_new     = odd_val - ((e_ext + right_val) >>> 1);
        h_left    = (idx == FIRST_EMIT) ? h_new : h_prev;
        l_new     = e_ext + ((h_left + h_new + ROUND) >>> 2);
    end

    // L always fits DW+2 bits, so the guard bit of the wide sum is dropped.
    assign unused_l_top = l_new[W-1];

    // Line position and stored samples; a reset discards any partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            x_even <= '0;
            x_odd  <= '0;
            h_prev <= '0;
        end else if (accept) begin
            idx <= is_last ? '0 : idx + 1'b1;
            if (is_even) begin
                x_even <= bus.s_data;
            end else begin
                x_odd <= bus.s_data;
            end
            if (emit) begin
                h_prev <= h_new;
            end
        end
    end

    // Output pair register: load on an emitting accept, clear valid once
    // drained, otherwise hold steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_L     <= '0;
            bus.m_H     <= '0;
            bus.m_last  <= 1'b0;
        end else if (emit) begin
            bus.m_valid <= 1'b1;
            bus.m_L     <= l_new[DW+1:0];
            bus.m_H     <= h_new[DW+1:0];
            bus.m_last  <= is_last;
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lift53_stream.sv
// Scoreboard bench for lift53_stream: expected pairs are queued as each line
// is issued and a negedge monitor pops and compares every delivered pair.
module tb_lift53_stream;

    localparam int DW       = 8;
    localparam int LINE_LEN = 8;
    localparam int NP       = LINE_LEN / 2;

    typedef struct {
        int l;
        int h;
        bit last;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pair_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    ready_mode = 0;
    int    gap_pct    = 0;

    always #5 clk = ~clk;

    lift53_stream_if #(.DW(DW)) bus ();

    lift53_stream #(.DW(DW), .LINE_LEN(LINE_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: whole-line lifting with mirrored ends, floors via >>>.
    function automatic void pushModel(input int x[LINE_LEN]);
        int    xe[LINE_LEN+1];
        int    h[NP];
        int    hl;
        pair_t p;
        for (int k = 0; k < LINE_LEN; k++) xe[k] = x[k];
        xe[LINE_LEN] = x[LINE_LEN-2];
        for (int n = 0; n < NP; n++)
            h[n] = xe[2*n+1] - ((xe[2*n] + xe[2*n+2]) >>> 1);
        for (int n = 0; n < NP; n++) begin
            hl     = (n == 0) ? h[0] : h[n-1];
            p.l    = xe[2*n] + ((hl + h[n] + 2) >>> 2);
            p.h    = h[n];
            p.last = (n == NP - 1);
            exp_q.push_back(p);
        end
    endfunction

    task automatic pushPair(input int l, input int h, input bit last);
        pair_t p;
        p.l = l;
        p.h = h;
        p.last = last;
        exp_q.push_back(p);
    endtask

    task automatic feedSample(input int v);
        int waited;
        while ($urandom_range(99) < gap_pct) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(v);
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            waited++;
            if (waited > 1000) begin
                checkOutput("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int x[LINE_LEN]);
        for (int k = 0; k < LINE_LEN; k++) feedSample(x[k]);
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    // Downstream ready generator: always ready, 1,0,0,1 pattern, or random.
    initial begin
        bit pattern[4];
        int ph;
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    bus.m_ready = pattern[ph % 4];
                    ph++;
                end
                2: bus.m_ready = ($urandom_range(1) == 1);
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshake rule, hold-under-backpressure, scoreboard pops.
    logic signed [DW+1:0] held_L;
    logic signed [DW+1:0] held_H;
    logic                 held_last;
    bit                   was_held = 1'b0;
    pair_t                got_exp;

    always @(negedge clk) begin
        if (rst) begin
            was_held = 1'b0;
        end else begin
            checkOutput("s_ready_rule", int'(bus.s_ready), int'(!bus.m_valid || bus.m_ready));
            if (was_held) begin
                checkOutput("hold_valid", int'(bus.m_valid), 1);
                checkOutput("hold_L", int'(bus.m_L), int'(held_L));
                checkOutput("hold_H", int'(bus.m_H), int'(held_H));
                checkOutput("hold_last", int'(bus.m_last), int'(held_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pair", 1, 0);
                end else begin
                    got_exp = exp_q.pop_front();
                    checkOutput("pair_L", int'(bus.m_L), got_exp.l);
                    checkOutput("pair_H", int'(bus.m_H), got_exp.h);
                    checkOutput("pair_last", int'(bus.m_last), int'(got_exp.last));
                end
            end
            was_held  = bus.m_valid && !bus.m_ready;
            held_L    = bus.m_L;
            held_H    = bus.m_H;
            held_last = bus.m_last;
        end
    end

    initial begin
        int d1[LINE_LEN];
        int d2[LINE_LEN];
        int d3[LINE_LEN];
        int rl[LINE_LEN];

        d1 = '{22, 44, 50, 70, 76, 86, 54, 76};
        d2 = '{100, 0, 100, 0, 100, 0, 100, 0};
        d3 = '{255, 0, 255, 0, 255, 0, 255, 0};
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", int'(bus.m_valid), 0);
        checkOutput("rst_m_L", int'(bus.m_L), 0);
        checkOutput("rst_m_H", int'(bus.m_H), 0);
        checkOutput("rst_m_last", int'(bus.m_last), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_s_ready", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;

        // Known line with hand-derived coefficients.
        pushPair(26, 8, 1'b0);
        pushPair(54, 7, 1'b0);
        pushPair(83, 21, 1'b0);
        pushPair(65, 22, 1'b1);
        applyStimulus(d1);

        // Negative H exercises the signed floors.
        pushPair(50, -100, 1'b0);
        pushPair(50, -100, 1'b0);
        pushPair(50, -100, 1'b0);
        pushPair(50, -100, 1'b1);
        applyStimulus(d2);

        // Back-to-back line with no gap must not inherit the previous line.
        pushPair(128, -255, 1'b0);
        pushPair(128, -255, 1'b0);
        pushPair(128, -255, 1'b0);
        pushPair(128, -255, 1'b1);
        applyStimulus(d3);
        drain();

        // Backpressure with ready pattern 1,0,0,1.
        ready_mode = 1;
        pushPair(26, 8, 1'b0);
        pushPair(54, 7, 1'b0);
        pushPair(83, 21, 1'b0);
        pushPair(65, 22, 1'b1);
        applyStimulus(d1);
        drain();

        // Random lines, random input gaps and random downstream stalls.
        ready_mode = 2;
        gap_pct    = 30;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < LINE_LEN; k++) begin
                case (t % 5)
                    0: rl[k] = 255;
                    1: rl[k] = (k % 2 == 0) ? 0 : 255;
                    default: rl[k] = int'($urandom_range(255));
                endcase
            end
            pushModel(rl);
            applyStimulus(rl);
        end
        drain();

        // Reset after five samples: only pair 0 reaches the output first.
        ready_mode = 0;
        gap_pct    = 0;
        repeat (2) @(posedge clk);
        #1;
        pushPair(26, 8, 1'b0);
        for (int k = 0; k < 5; k++) feedSample(d1[k]);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_m_valid", int'(bus.m_valid), 0);
        checkOutput("midrst_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pushModel(d1);
        applyStimulus(d1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
